// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: buffers issued ops, snoops write-back channels for
// operands and offers the oldest ready entry (by ROB distance from head) to one execution unit.
module rs_age_ordered #(
  parameter int DEPTH     = 8,
  parameter int DEPTH_BIT = 3,
  parameter int ROB_BIT   = 4,
  parameter int TYPE_BIT  = 5,
  parameter int XLEN      = 32,
  parameter int NUM_WB    = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       rob_clear,
  input  logic [ROB_BIT-1:0]         rob_head,
  input  logic                       inst_valid,
  input  logic [TYPE_BIT-1:0]        inst_type,
  input  logic [ROB_BIT-1:0]         inst_rob_idx,
  input  logic [XLEN-1:0]            inst_r1,
  input  logic [XLEN-1:0]            inst_r2,
  input  logic [ROB_BIT-1:0]         inst_dep1,
  input  logic [ROB_BIT-1:0]         inst_dep2,
  input  logic                       inst_has_dep1,
  input  logic                       inst_has_dep2,
  output logic                       full,
  output logic [DEPTH_BIT:0]         count,
  output logic                       exe_valid,
  input  logic                       exe_ready,
  output logic [TYPE_BIT-1:0]        exe_op,
  output logic [XLEN-1:0]            exe_r1,
  output logic [XLEN-1:0]            exe_r2,
  output logic [ROB_BIT-1:0]         exe_rob_idx,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_BIT-1:0]  wb_idx,
  input  logic [NUM_WB*XLEN-1:0]     wb_value
);

  localparam logic [DEPTH_BIT:0] COUNT_FULL = (DEPTH_BIT+1)'(DEPTH);

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DEPTH-1:0]    hd1_q, hd1_d;
  logic [DEPTH-1:0]    hd2_q, hd2_d;
  logic [TYPE_BIT-1:0] type_q [DEPTH];
  logic [TYPE_BIT-1:0] type_d [DEPTH];
  logic [ROB_BIT-1:0]  rob_q  [DEPTH];
  logic [ROB_BIT-1:0]  rob_d  [DEPTH];
  logic [ROB_BIT-1:0]  dep1_q [DEPTH];
  logic [ROB_BIT-1:0]  dep1_d [DEPTH];
  logic [ROB_BIT-1:0]  dep2_q [DEPTH];
  logic [ROB_BIT-1:0]  dep2_d [DEPTH];
  logic [XLEN-1:0]     r1_q   [DEPTH];
  logic [XLEN-1:0]     r1_d   [DEPTH];
  logic [XLEN-1:0]     r2_q   [DEPTH];
  logic [XLEN-1:0]     r2_d   [DEPTH];
  logic [DEPTH_BIT:0]  count_q, count_d;
  logic                full_q, full_d;

  logic [ROB_BIT-1:0]  wb_tag [NUM_WB];
  logic [XLEN-1:0]     wb_val [NUM_WB];
  logic [ROB_BIT-1:0]  age_w  [DEPTH];
  logic [DEPTH-1:0]    ready_w;

  logic                 sel_found;
  logic [DEPTH_BIT-1:0] sel_idx;
  logic [ROB_BIT-1:0]   sel_age;
  logic                 free_found;
  logic [DEPTH_BIT-1:0] free_idx;
  logic                 dispatch;
  logic                 insert_acc;
  logic                 byp1_hit, byp2_hit;
  logic [XLEN-1:0]      byp1_val, byp2_val;

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
    assign wb_tag[k] = wb_idx[k*ROB_BIT +: ROB_BIT];
    assign wb_val[k] = wb_value[k*XLEN +: XLEN];
  end

  // Age is the modular distance from the ROB head, so wrap of the tag space is harmless.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign age_w[i] = rob_q[i] - rob_head;
  end

  assign ready_w = busy_q & ~hd1_q & ~hd2_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_w[i] && (!sel_found || (age_w[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = DEPTH_BIT'(i);
        sel_age   = age_w[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = DEPTH_BIT'(i);
      end
    end
  end

  // Scanning channels from high to low lets the lowest matching channel win.
  always_comb begin
    byp1_hit = 1'b0;
    byp1_val = inst_r1;
    byp2_hit = 1'b0;
    byp2_val = inst_r2;
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (inst_has_dep1 && wb_valid[k] && (wb_tag[k] == inst_dep1)) begin
        byp1_hit = 1'b1;
        byp1_val = wb_val[k];
      end
      if (inst_has_dep2 && wb_valid[k] && (wb_tag[k] == inst_dep2)) begin
        byp2_hit = 1'b1;
        byp2_val = wb_val[k];
      end
    end
  end

  assign exe_valid   = rdy_in & sel_found;
  assign dispatch    = exe_valid & exe_ready;
  assign insert_acc  = rdy_in & ~rob_clear & inst_valid & ~full_q & free_found;
  assign exe_op      = type_q[sel_idx];
  assign exe_r1      = r1_q[sel_idx];
  assign exe_r2      = r2_q[sel_idx];
  assign exe_rob_idx = rob_q[sel_idx];
  assign full        = full_q;
  assign count       = count_q;

  always_comb begin
    busy_d  = busy_q;
    hd1_d   = hd1_q;
    hd2_d   = hd2_q;
    type_d  = type_q;
    rob_d   = rob_q;
    dep1_d  = dep1_q;
    dep2_d  = dep2_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    count_d = count_q;
    if (rdy_in) begin
      if (rob_clear) begin
        busy_d  = '0;
        count_d = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          for (int k = NUM_WB-1; k >= 0; k--) begin
            if (busy_q[i] && hd1_q[i] && wb_valid[k] && (wb_tag[k] == dep1_q[i])) begin
              r1_d[i]  = wb_val[k];
              hd1_d[i] = 1'b0;
            end
            if (busy_q[i] && hd2_q[i] && wb_valid[k] && (wb_tag[k] == dep2_q[i])) begin
              r2_d[i]  = wb_val[k];
              hd2_d[i] = 1'b0;
            end
          end
        end
        if (dispatch) begin
          busy_d[sel_idx] = 1'b0;
        end
        // free_idx only names slots idle in the current state, so a slot vacated
        // by this cycle's dispatch is not reused until the next cycle.
        if (insert_acc) begin
          busy_d[free_idx] = 1'b1;
          type_d[free_idx] = inst_type;
          rob_d[free_idx]  = inst_rob_idx;
          dep1_d[free_idx] = inst_dep1;
          dep2_d[free_idx] = inst_dep2;
          r1_d[free_idx]   = byp1_val;
          r2_d[free_idx]   = byp2_val;
          hd1_d[free_idx]  = inst_has_dep1 & ~byp1_hit;
          hd2_d[free_idx]  = inst_has_dep2 & ~byp2_hit;
        end
        count_d = count_q + {{DEPTH_BIT{1'b0}}, insert_acc} - {{DEPTH_BIT{1'b0}}, dispatch};
      end
    end
    full_d = (count_d == COUNT_FULL);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      hd1_q   <= '0;
      hd2_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        rob_q[i]  <= '0;
        dep1_q[i] <= '0;
        dep2_q[i] <= '0;
        r1_q[i]   <= '0;
        r2_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      hd1_q   <= hd1_d;
      hd2_q   <= hd2_d;
      count_q <= count_d;
      full_q  <= full_d;
      type_q  <= type_d;
      rob_q   <= rob_d;
      dep1_q  <= dep1_d;
      dep2_q  <= dep2_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
    end
  end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed scenarios plus random traffic, all outputs compared
// each cycle against a queue-based model of the station.
module tb_rs_age_ordered;
  localparam int DEPTH = 8, DEPTH_BIT = 3, ROB_BIT = 4, TYPE_BIT = 5, XLEN = 32, NUM_WB = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                      rst_in, rdy_in, rob_clear, inst_valid, inst_has_dep1, inst_has_dep2, exe_ready;
  logic [ROB_BIT-1:0]        rob_head, inst_rob_idx, inst_dep1, inst_dep2, exe_rob_idx;
  logic [TYPE_BIT-1:0]       inst_type, exe_op;
  logic [XLEN-1:0]           inst_r1, inst_r2, exe_r1, exe_r2;
  logic                      full, exe_valid;
  logic [DEPTH_BIT:0]        count;
  logic [NUM_WB-1:0]         wb_valid;
  logic [NUM_WB*ROB_BIT-1:0] wb_idx;
  logic [NUM_WB*XLEN-1:0]    wb_value;

  rs_age_ordered #(.DEPTH(DEPTH), .DEPTH_BIT(DEPTH_BIT), .ROB_BIT(ROB_BIT), .TYPE_BIT(TYPE_BIT),
                   .XLEN(XLEN), .NUM_WB(NUM_WB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear), .rob_head(rob_head),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_idx(inst_rob_idx),
    .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
    .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2), .full(full), .count(count),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_op(exe_op), .exe_r1(exe_r1), .exe_r2(exe_r2),
    .exe_rob_idx(exe_rob_idx), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value)
  );

  typedef struct {
    logic [TYPE_BIT-1:0] typ;
    logic [ROB_BIT-1:0]  tag;
    logic [XLEN-1:0]     r1, r2;
    logic [ROB_BIT-1:0]  d1, d2;
    bit                  h1, h2;
  } ent_t;

  ent_t             mq[$];
  logic [ROB_BIT-1:0] disp_log[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int age_of(input logic [ROB_BIT-1:0] tag);
    return (int'(tag) - int'(rob_head) + (1 << ROB_BIT)) % (1 << ROB_BIT);
  endfunction

  function automatic int model_sel();
    int best = -1;
    int best_age = 1 << ROB_BIT;
    foreach (mq[i]) begin
      if (!mq[i].h1 && !mq[i].h2 && age_of(mq[i].tag) < best_age) begin
        best_age = age_of(mq[i].tag);
        best = i;
      end
    end
    return best;
  endfunction

  function automatic void snoop(input logic [ROB_BIT-1:0] dep, inout bit h, inout logic [XLEN-1:0] v);
    for (int k = 0; k < NUM_WB; k++) begin
      if (h && wb_valid[k] && wb_idx[k*ROB_BIT +: ROB_BIT] == dep) begin
        v = wb_value[k*XLEN +: XLEN];
        h = 1'b0;
      end
    end
  endfunction

  // Check the current offer against the model, advance the model, then step one clock.
  task automatic cycle();
    int s;
    bit ev, acc;
    ent_t e;
    #1;
    s  = model_sel();
    ev = rdy_in && (s >= 0);
    chk("exe_valid", exe_valid, ev);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    if (ev) begin
      chk("exe_rob_idx", exe_rob_idx, mq[s].tag);
      chk("exe_op", exe_op, mq[s].typ);
      chk("exe_r1", exe_r1, mq[s].r1);
      chk("exe_r2", exe_r2, mq[s].r2);
    end
    if (rdy_in) begin
      if (rob_clear) mq.delete();
      else begin
        acc = inst_valid && (mq.size() < DEPTH);
        if (ev && exe_ready) begin
          disp_log.push_back(mq[s].tag);
          mq.delete(s);
        end
        foreach (mq[i]) begin
          e = mq[i];
          snoop(e.d1, e.h1, e.r1);
          snoop(e.d2, e.h2, e.r2);
          mq[i] = e;
        end
        if (acc) begin
          e.typ = inst_type; e.tag = inst_rob_idx;
          e.r1 = inst_r1; e.r2 = inst_r2;
          e.d1 = inst_dep1; e.d2 = inst_dep2;
          e.h1 = inst_has_dep1; e.h2 = inst_has_dep2;
          snoop(e.d1, e.h1, e.r1);
          snoop(e.d2, e.h2, e.r2);
          mq.push_back(e);
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic issue(input logic [ROB_BIT-1:0] tag, input bit h1, input logic [ROB_BIT-1:0] d1,
                       input bit h2, input logic [ROB_BIT-1:0] d2);
    inst_valid = 1'b1; inst_rob_idx = tag; inst_type = TYPE_BIT'($urandom);
    inst_r1 = $urandom; inst_r2 = $urandom;
    inst_has_dep1 = h1; inst_dep1 = d1; inst_has_dep2 = h2; inst_dep2 = d2;
  endtask

  task automatic no_issue();
    inst_valid = 1'b0; inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0;
  endtask

  task automatic wb_off();
    wb_valid = '0; wb_idx = '0; wb_value = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ROB_BIT-1:0] t;
    bit used;
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; rob_head = '0; exe_ready = 1'b0;
    inst_type = '0; inst_rob_idx = '0; inst_r1 = '0; inst_r2 = '0; inst_dep1 = '0; inst_dep2 = '0;
    no_issue(); wb_off();
    #3;
    chk("rst_count", count, 0); chk("rst_full", full, 0); chk("rst_exe_valid", exe_valid, 0);
    chk("rst_exe_op", exe_op, 0); chk("rst_exe_rob_idx", exe_rob_idx, 0);
    chk("rst_exe_r1", exe_r1, 0); chk("rst_exe_r2", exe_r2, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Asynchronous reset in the middle of operation
    issue(2, 0, 0, 0, 0); cycle();
    issue(3, 0, 0, 0, 0); cycle();
    issue(4, 0, 0, 0, 0); cycle();
    no_issue();
    chk("pre_rst_count", count, 3);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_count", count, 0); chk("async_rst_full", full, 0); chk("async_rst_valid", exe_valid, 0);
    mq.delete();
    @(negedge clk_in);
    rst_in = 1'b0; exe_ready = 1'b1;
    cycle(); cycle();

    // Age order across the ROB tag wrap
    rob_head = 4'd14; exe_ready = 1'b0; disp_log.delete();
    issue(1, 0, 0, 0, 0);  cycle();
    issue(15, 0, 0, 0, 0); cycle();
    issue(14, 0, 0, 0, 0); cycle();
    no_issue(); exe_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("age_count", count, 3 - j);
      if (j < 3) cycle();
    end
    chk("age_n_disp", disp_log.size(), 3);
    if (disp_log.size() == 3) begin
      chk("age_disp0", disp_log[0], 14); chk("age_disp1", disp_log[1], 15); chk("age_disp2", disp_log[2], 1);
    end

    // Backpressure holds a stable offer
    rob_head = '0; exe_ready = 1'b0;
    issue(5, 0, 0, 0, 0); cycle();
    no_issue();
    for (int j = 0; j < 4; j++) begin
      chk("bp_valid", exe_valid, 1); chk("bp_tag", exe_rob_idx, 5); chk("bp_count", count, 1);
      cycle();
    end
    exe_ready = 1'b1; cycle();
    chk("bp_drain", count, 0);

    // Insert bypass and later wakeup
    exe_ready = 1'b0;
    issue(3, 1, 7, 0, 0);
    wb_valid = 2'b10; wb_idx = {4'd7, 4'd0}; wb_value = {32'hDEAD, 32'h0};
    cycle();
    no_issue(); wb_off();
    chk("byp_valid", exe_valid, 1); chk("byp_r1", exe_r1, 32'hDEAD); chk("byp_tag", exe_rob_idx, 3);
    exe_ready = 1'b1; cycle();
    issue(4, 0, 0, 1, 9); cycle();
    no_issue(); cycle();
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd9}; wb_value = {32'h0, 32'h42};
    chk("wake_pending", exe_valid, 0);
    cycle();
    wb_off();
    chk("wake_valid", exe_valid, 1); chk("wake_r2", exe_r2, 32'h42); chk("wake_tag", exe_rob_idx, 4);
    cycle();
    chk("wake_drain", count, 0);

    // Full boundary
    for (int i = 0; i < DEPTH; i++) begin
      issue(ROB_BIT'(i), 1, ROB_BIT'(8 + i), 0, 0); cycle();
    end
    chk("full_set", full, 1); chk("full_count", count, 8);
    issue(12, 0, 0, 0, 0); cycle();
    no_issue();
    chk("full_ignored", count, 8);
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd8}; wb_value = {32'h0, 32'h111};
    cycle();
    wb_off();
    chk("full_wake_valid", exe_valid, 1); chk("full_wake_tag", exe_rob_idx, 0); chk("full_still", full, 1);
    cycle();
    chk("full_clear", full, 0); chk("full_count7", count, 7);

    // Flush and stall
    rob_clear = 1'b1; cycle(); rob_clear = 1'b0;
    chk("clr_count", count, 0);
    for (int i = 0; i < 4; i++) begin
      issue(ROB_BIT'(i), 1, ROB_BIT'(10 + i), 0, 0); cycle();
    end
    no_issue();
    rdy_in = 1'b0;
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd10}; wb_value = {32'h0, 32'h55};
    for (int j = 0; j < 2; j++) begin
      chk("stall_valid", exe_valid, 0); cycle();
    end
    rdy_in = 1'b1; wb_off();
    chk("stall_pending", exe_valid, 0); chk("stall_count", count, 4);
    cycle();
    rob_clear = 1'b1; issue(5, 0, 0, 0, 0); cycle();
    rob_clear = 1'b0; no_issue();
    chk("flush_count", count, 0); chk("flush_valid", exe_valid, 0);
    cycle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 49) == 0);
      rob_head  = ROB_BIT'($urandom);
      exe_ready = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        do begin
          t = ROB_BIT'($urandom);
          used = 1'b0;
          foreach (mq[i]) if (mq[i].tag == t) used = 1'b1;
        end while (used);
        issue(t, $urandom_range(0, 1), ROB_BIT'($urandom), $urandom_range(0, 1), ROB_BIT'($urandom));
      end else no_issue();
      for (int k = 0; k < NUM_WB; k++) begin
        wb_valid[k] = ($urandom_range(0, 1) == 1);
        wb_idx[k*ROB_BIT +: ROB_BIT] = ROB_BIT'($urandom);
        wb_value[k*XLEN +: XLEN] = $urandom;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
